ship_placement_controller: RTL and testbench

SHIP_PLACEMENT_CONTROLLER -- requirements
Module: ship_placement_controller

---
 rtl/ship_placement_if.sv | 32 +++
 rtl/ship_placement_controller.sv | 183 ++++++++++++++++++
 tb/tb_ship_placement_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ship_placement_if.sv
// Handshake bundle between the placement controller and its user/display side.
// The master drives the buttons and cursor; the slave drives board state and grid writes.
interface ship_placement_if;
  logic        start;
  logic        place_btn;
  logic        rotate_btn;
  logic [3:0]  cursor_x;
  logic [3:0]  cursor_y;
  logic [3:0]  current_ship_length;
  logic        orientation;
  logic [2:0]  ship_count;
  logic        wr_en;
  logic [3:0]  wr_x;
  logic [3:0]  wr_y;
  logic [99:0] grid;
  logic        placed;
  logic        reject;
  logic        placement_done;
  logic        busy;

  modport master (
    output start, place_btn, rotate_btn, cursor_x, cursor_y,
    input  current_ship_length, orientation, ship_count, wr_en, wr_x, wr_y,
    input  grid, placed, reject, placement_done, busy
  );

  modport slave (
    input  start, place_btn, rotate_btn, cursor_x, cursor_y,
    output current_ship_length, orientation, ship_count, wr_en, wr_x, wr_y,
    output grid, placed, reject, placement_done, busy
  );
endinterface

// File: rtl/ship_placement_controller.sv
// Places a fixed fleet (5,4,3,3,2) on a 10x10 board: per-cell collision scan, then
// per-cell commit with a grid write strobe.
//
// state  | meaning
// IDLE   | waiting for start, board inactive
// SELECT | user moves cursor, may rotate or request placement
// CHECK  | scanning one cell per cycle for bounds/overlap
// COMMIT | writing one cell per cycle into the grid
// DONE   | all five ships committed
module ship_placement_controller (
  input  logic              clk,
  input  logic              rst,
  ship_placement_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CHECK,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ship_count_q, ship_count_d;
  logic        orientation_q, orientation_d;
  logic [99:0] grid_q, grid_d;
  logic [3:0]  base_x_q, base_x_d;
  logic [3:0]  base_y_q, base_y_d;
  logic [2:0]  k_q, k_d;
  logic        placed_q, placed_d;
  logic        reject_q, reject_d;

  logic [3:0]  ship_len;
  logic [3:0]  cell_x;
  logic [3:0]  cell_y;
  logic [6:0]  cell_idx;
  logic        cell_in_range;
  logic        collision;
  logic        last_cell;

  always_comb begin
    case (ship_count_q)
      3'd0:    ship_len = 4'd5;
      3'd1:    ship_len = 4'd4;
      3'd2:    ship_len = 4'd3;
      3'd3:    ship_len = 4'd3;
      3'd4:    ship_len = 4'd2;
      default: ship_len = 4'd0;
    endcase
  end

  // Sums stay within 4 bits (at most 9+4); the index is only meaningful when in range.
  assign cell_x        = orientation_q ? base_x_q : (base_x_q + {1'b0, k_q});
  assign cell_y        = orientation_q ? (base_y_q + {1'b0, k_q}) : base_y_q;
  assign cell_in_range = (cell_x <= 4'd9) && (cell_y <= 4'd9);
  assign cell_idx      = ({3'b000, cell_y} * 7'd10) + {3'b000, cell_x};
  assign collision     = !cell_in_range || grid_q[cell_idx];
  assign last_cell     = ({1'b0, k_q} == (ship_len - 4'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ship_count_q  <= 3'd0;
      orientation_q <= 1'b0;
      grid_q        <= '0;
      base_x_q      <= 4'd0;
      base_y_q      <= 4'd0;
      k_q           <= 3'd0;
      placed_q      <= 1'b0;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ship_count_q  <= ship_count_d;
      orientation_q <= orientation_d;
      grid_q        <= grid_d;
      base_x_q      <= base_x_d;
      base_y_q      <= base_y_d;
      k_q           <= k_d;
      placed_q      <= placed_d;
      reject_q      <= reject_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ship_count_d  = ship_count_q;
    orientation_d = orientation_q;
    grid_d        = grid_q;
    base_x_d      = base_x_q;
    base_y_d      = base_y_q;
    k_d           = k_q;
    placed_d      = 1'b0;
    reject_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_SELECT;
          grid_d        = '0;
          ship_count_d  = 3'd0;
          orientation_d = 1'b0;
        end
      end

      S_SELECT: begin
        if (bus.start) begin
          state_d       = S_SELECT;
          grid_d        = '0;
          ship_count_d  = 3'd0;
          orientation_d = 1'b0;
        end else if (bus.place_btn) begin
          // Place takes priority; a coincident rotate press is dropped.
          state_d  = S_CHECK;
          base_x_d = bus.cursor_x;
          base_y_d = bus.cursor_y;
          k_d      = 3'd0;
        end else if (bus.rotate_btn) begin
          orientation_d = !orientation_q;
        end
      end

      S_CHECK: begin
        if (collision) begin
          state_d  = S_SELECT;
          reject_d = 1'b1;
          k_d      = 3'd0;
        end else if (last_cell) begin
          state_d = S_COMMIT;
          k_d     = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      S_COMMIT: begin
        grid_d[cell_idx] = 1'b1;
        if (last_cell) begin
          ship_count_d = ship_count_q + 3'd1;
          placed_d     = 1'b1;
          k_d          = 3'd0;
          state_d      = (ship_count_q == 3'd4) ? S_DONE : S_SELECT;
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      S_DONE: begin
        if (bus.start) begin
          state_d       = S_SELECT;
          grid_d        = '0;
          ship_count_d  = 3'd0;
          orientation_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.current_ship_length = 4'd0;
    bus.wr_en               = 1'b0;
    bus.wr_x                = 4'd0;
    bus.wr_y                = 4'd0;
    if (state_q == S_SELECT || state_q == S_CHECK || state_q == S_COMMIT)
      bus.current_ship_length = ship_len;
    if (state_q == S_COMMIT) begin
      bus.wr_en = 1'b1;
      bus.wr_x  = cell_x;
      bus.wr_y  = cell_y;
    end
  end

  assign bus.orientation    = orientation_q;
  assign bus.ship_count     = ship_count_q;
  assign bus.grid           = grid_q;
  assign bus.placed         = placed_q;
  assign bus.reject         = reject_q;
  assign bus.placement_done = (state_q == S_DONE);
  assign bus.busy           = (state_q == S_CHECK) || (state_q == S_COMMIT);

endmodule

// File: tb/tb_ship_placement_controller.sv
// Directed bench for ship_placement_controller: a per-cycle vector table for the first
// ship and a rejected placement, then hand sequences for bounds, full fleet and reset.
module tb_ship_placement_controller;

  logic clk;
  logic rst;
  ship_placement_if bus ();

  ship_placement_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       s, p, r;
    logic [3:0] x, y;
    logic [3:0] len;
    logic       ori;
    logic [2:0] cnt;
    logic       wr;
    logic [3:0] wx, wy;
    logic       pl, rj, bsy, dn;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic s, logic p, logic r, logic [3:0] x, logic [3:0] y,
                              logic [3:0] len, logic ori, logic [2:0] cnt, logic wr,
                              logic [3:0] wx, logic [3:0] wy, logic pl, logic rj,
                              logic bsy, logic dn);
    vec_t v;
    v.s = s; v.p = p; v.r = r; v.x = x; v.y = y;
    v.len = len; v.ori = ori; v.cnt = cnt; v.wr = wr; v.wx = wx; v.wy = wy;
    v.pl = pl; v.rj = rj; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  task automatic chk(string name, logic [99:0] act, logic [99:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(logic s, logic p, logic r, logic [3:0] x, logic [3:0] y);
    bus.start      = s;
    bus.place_btn  = p;
    bus.rotate_btn = r;
    bus.cursor_x   = x;
    bus.cursor_y   = y;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.place_btn  = 1'b0;
    bus.rotate_btn = 1'b0;
  endtask

  // Counts edges from the place press (inclusive) until placed or reject, bounded.
  task automatic wait_result(output int lat, output bit got_placed, output bit got_reject);
    lat = 1;
    got_placed = bus.placed;
    got_reject = bus.reject;
    while (!got_placed && !got_reject && lat < 40) begin
      step(1'b0, 1'b0, 1'b0, bus.cursor_x, bus.cursor_y);
      lat++;
      got_placed = bus.placed;
      got_reject = bus.reject;
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, ".len"},  100'(bus.current_ship_length), 100'd0);
    chk({tag, ".ori"},  100'(bus.orientation), 100'd0);
    chk({tag, ".cnt"},  100'(bus.ship_count), 100'd0);
    chk({tag, ".wr"},   100'(bus.wr_en), 100'd0);
    chk({tag, ".wx"},   100'(bus.wr_x), 100'd0);
    chk({tag, ".wy"},   100'(bus.wr_y), 100'd0);
    chk({tag, ".grid"}, bus.grid, 100'd0);
    chk({tag, ".pl"},   100'(bus.placed), 100'd0);
    chk({tag, ".rj"},   100'(bus.reject), 100'd0);
    chk({tag, ".bsy"},  100'(bus.busy), 100'd0);
    chk({tag, ".dn"},   100'(bus.placement_done), 100'd0);
  endtask

  initial begin
    int lat;
    bit gp, gr;
    int nchk, ncommit;
    bit saw_wr;
    logic [99:0] exp_grid;
    int lens [5];
    lens = '{5, 4, 3, 3, 2};

    // First ship at (0,0) horizontal, then a vertical attempt at (2,0) that collides.
    // Rotate in CHECK, place and start in COMMIT must be ignored.
    //               s  p  r  x  y   len ori cnt wr wx wy pl rj bsy dn
    tbl[0]  = mk(1, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0,  5, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(0, 1, 0, 3, 3,  5, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0,  5, 0, 0, 1, 2, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0,  5, 0, 0, 1, 3, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 0,  5, 0, 0, 1, 4, 0, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0,  4, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0,  4, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 0,  4, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 2, 0,  4, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 2, 0,  4, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    tbl[16] = mk(0, 0, 0, 2, 0,  4, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 1, 2, 0,  4, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    bus.start = 1'b0; bus.place_btn = 1'b0; bus.rotate_btn = 1'b0;
    bus.cursor_x = 4'd0; bus.cursor_y = 4'd0;
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    step(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    chk("idle_ignores_btn.bsy", 100'(bus.busy), 100'd0);
    chk("idle_ignores_btn.ori", 100'(bus.orientation), 100'd0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].s, tbl[i].p, tbl[i].r, tbl[i].x, tbl[i].y);
      chk($sformatf("v%0d.len", i), 100'(bus.current_ship_length), 100'(tbl[i].len));
      chk($sformatf("v%0d.ori", i), 100'(bus.orientation),         100'(tbl[i].ori));
      chk($sformatf("v%0d.cnt", i), 100'(bus.ship_count),          100'(tbl[i].cnt));
      chk($sformatf("v%0d.wr", i),  100'(bus.wr_en),               100'(tbl[i].wr));
      chk($sformatf("v%0d.wx", i),  100'(bus.wr_x),                100'(tbl[i].wx));
      chk($sformatf("v%0d.wy", i),  100'(bus.wr_y),                100'(tbl[i].wy));
      chk($sformatf("v%0d.pl", i),  100'(bus.placed),              100'(tbl[i].pl));
      chk($sformatf("v%0d.rj", i),  100'(bus.reject),              100'(tbl[i].rj));
      chk($sformatf("v%0d.bsy", i), 100'(bus.busy),                100'(tbl[i].bsy));
      chk($sformatf("v%0d.dn", i),  100'(bus.placement_done),      100'(tbl[i].dn));
    end
    chk("ship0.grid", bus.grid, 100'h1F);

    // Horizontal length 4 at (7,5): cell (10,5) is out of range on the 4th scan cycle.
    step(1'b0, 1'b1, 1'b0, 4'd7, 4'd5);
    nchk = bus.busy ? 1 : 0;
    saw_wr = bus.wr_en;
    gr = 1'b0;
    for (int i = 0; i < 10 && !gr; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd7, 4'd5);
      if (bus.busy) nchk++;
      if (bus.wr_en) saw_wr = 1'b1;
      gr = bus.reject;
    end
    chk("edge.reject_seen", 100'(gr), 100'd1);
    chk("edge.check_cycles", 100'(nchk), 100'd4);
    chk("edge.no_write", 100'(saw_wr), 100'd0);
    chk("edge.grid", bus.grid, 100'h1F);
    chk("edge.cnt", 100'(bus.ship_count), 100'd1);

    // Full fleet after restart from SELECT.
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    chk("restart.cnt", 100'(bus.ship_count), 100'd0);
    chk("restart.grid", bus.grid, 100'd0);
    exp_grid = '0;
    for (int s = 0; s < 5; s++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 4'(2 * s));
      wait_result(lat, gp, gr);
      chk($sformatf("fleet%0d.placed", s), 100'(gp), 100'd1);
      chk($sformatf("fleet%0d.latency", s), 100'(lat), 100'(2 * lens[s] + 1));
      for (int c = 0; c < lens[s]; c++) exp_grid[20 * s + c] = 1'b1;
    end
    chk("fleet.cnt", 100'(bus.ship_count), 100'd5);
    chk("fleet.done", 100'(bus.placement_done), 100'd1);
    chk("fleet.len", 100'(bus.current_ship_length), 100'd0);
    chk("fleet.grid", bus.grid, exp_grid);
    chk("fleet.popcount", 100'($countones(bus.grid)), 100'd17);

    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd1);
    chk("done_ignores_place.bsy", 100'(bus.busy), 100'd0);
    chk("done_ignores_place.dn", 100'(bus.placement_done), 100'd1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    chk("done_restart.cnt", 100'(bus.ship_count), 100'd0);
    chk("done_restart.grid", bus.grid, 100'd0);
    chk("done_restart.dn", 100'(bus.placement_done), 100'd0);
    chk("done_restart.len", 100'(bus.current_ship_length), 100'd5);

    // Coincident place and rotate: place wins, orientation stays horizontal.
    step(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
    chk("coincide.ori", 100'(bus.orientation), 100'd0);
    chk("coincide.bsy", 100'(bus.busy), 100'd1);
    wait_result(lat, gp, gr);
    chk("coincide.latency", 100'(lat), 100'd11);
    chk("coincide.grid", bus.grid, 100'h1F);

    // Vertical length 4 at (9,2); reset lands in the 3rd commit cycle.
    step(1'b0, 1'b0, 1'b1, 4'd9, 4'd2);
    chk("vert.ori", 100'(bus.orientation), 100'd1);
    step(1'b0, 1'b1, 1'b0, 4'd9, 4'd2);
    ncommit = 0;
    for (int i = 0; i < 20 && ncommit < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'd9, 4'd2);
      if (bus.wr_en) begin
        ncommit++;
        chk($sformatf("vert.c%0d.wx", ncommit), 100'(bus.wr_x), 100'd9);
        chk($sformatf("vert.c%0d.wy", ncommit), 100'(bus.wr_y), 100'(2 + ncommit - 1));
      end
    end
    chk("vert.reached_commit3", 100'(ncommit), 100'd3);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midcommit_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("post_rst_idle.bsy", 100'(bus.busy), 100'd0);
    chk("post_rst_idle.len", 100'(bus.current_ship_length), 100'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
